common_dffram_burst_reader: RTL and testbench
=============================================

Name: common_dffram_burst_reader

Overview:
Read-side burst engine for the DFF-based single-port RAM. It accepts a burst command (start address, beat count) and drives the RAM address/enable with write-enable held low. It captures the RAM's combinational read data into an output register and presents it on a valid/ready stream with a last flag. It sits between a RAM instance and any consumer that drains table contents sequentially, such as table dump, scrub or copy-out logic.

Parameters:
RAM_DATA_WIDTH, 1, width of RAM word and out_data
RAM_ADDR_WIDTH, 1, RAM address width; RAM depth is 2^RAM_ADDR_WIDTH
LEN_WIDTH, 4, width of cmd_len; a burst has cmd_len+1 beats

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
cmd_valid  input  1  burst command valid
cmd_ready  output  1  engine accepts command; high only in IDLE
cmd_addr  input  RAM_ADDR_WIDTH  first beat address
cmd_len  input  LEN_WIDTH  beats minus one
abort  input  1  synchronous burst cancel
ram_addr  output  RAM_ADDR_WIDTH  RAM address
ram_en  output  1  RAM enable (read issue)
ram_we  output  1  RAM write enable, constant 0
ram_dout  input  RAM_DATA_WIDTH  RAM combinational read data for ram_addr
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts beat
out_data  output  RAM_DATA_WIDTH  beat data
out_last  output  1  marks final beat of burst
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, out_valid=0, out_last=0, out_data=0, internal addr/count=0. Outputs: ram_en=0, ram_addr=0, cmd_ready=1, busy=0.
- States: IDLE, READ (beats left to issue), DRAIN (all issued, last beat not yet consumed).
- IDLE: cmd_ready=1. On cmd_valid: latch cur_addr=cmd_addr and remaining=cmd_len, go to READ. Commands are ignored in other states (cmd_ready=0).
- Slot free = !out_valid | out_ready.
- READ: ram_addr=cur_addr always. ram_en=1 iff slot free, and a beat is issued that cycle.
- On issue: out_data<=ram_dout, out_valid<=1, out_last<=(remaining==0).
- On issue with remaining!=0: cur_addr<=cur_addr+1, wrapping mod 2^RAM_ADDR_WIDTH (last address wraps to 0); remaining<=remaining-1.
- On issue with remaining==0: go to DRAIN.
- Outside a READ issue, ram_en=0 and ram_addr holds cur_addr.
- Any cycle without an issue: if out_valid&out_ready then out_valid<=0 and out_last<=0.
- DRAIN: when out_valid&out_ready&out_last, clear out_valid and out_last and go to IDLE.
- Latency: command handshake at edge T enters READ; first beat issued in cycle T+1 and out_valid=1 after edge T+1. Sustained throughput is 1 beat/cycle with out_ready=1. With out_ready=0, out_data/out_last stay stable and ram_en=0 (no issue).
- Burst of N beats with out_ready stuck 1: exactly N consecutive out_valid cycles, out_last only on the Nth; back in IDLE one cycle after the Nth transfer.
- cmd_len max (2^LEN_WIDTH-1): 2^LEN_WIDTH beats. If this exceeds RAM depth, addresses wrap and repeat.
- abort=1 in READ or DRAIN: next state IDLE, out_valid<=0, out_last<=0, no issue that cycle (ram_en=0). A beat presented in the abort cycle counts as transferred only if out_ready=1 that cycle. abort in IDLE has no effect and does not block a command.
- Reset mid-burst: immediate return to reset values; no partial beat is held.
- out_data holds its last value when out_valid=0. Data reflects RAM contents in the issue cycle; concurrent writes by other agents are not ordered by this block.

Test Plan:
- RAM_ADDR_WIDTH=3 with words[i]=i+0x10; cmd addr=2 len=3, out_ready=1 -> beats 0x12,0x13,0x14,0x15 on consecutive cycles, out_last only on 0x15, first out_valid 2 edges after cmd, busy drops next cycle.
- Wrap: cmd addr=6 len=3 -> ram_addr 6,7,0,1; data 0x16,0x17,0x10,0x11.
- Backpressure: addr=0 len=2 with out_ready toggling 1,0,0,1,1 -> out_data stable while stalled, ram_en=0 during stall, exactly 3 beats 0x10,0x11,0x12, no duplicates or drops.
- Abort: addr=0 len=7, abort on 3rd out_valid cycle with out_ready=0 -> out_valid=0 next cycle, state IDLE, cmd_ready=1; a new cmd addr=5 len=0 issued immediately yields single beat 0x15 with out_last=1.
- Reset mid-burst: reset=0 asynchronously during DRAIN -> out_valid/out_last/busy/ram_en=0 without waiting for a clock edge; after release, cmd_ready=1.
- Busy gating: cmd_valid held during burst -> cmd_ready=0 until IDLE; second command accepted exactly the cycle after the first burst's last transfer; ram_we=0 throughout.

Source files
------------

// File: rtl/common_dffram_burst_reader.sv
// Read-side burst engine for a DFF-based single-port RAM.
// Takes a (start address, beat count) command, walks the RAM with write
// enable held low, registers each combinational read word and streams it
// out on a valid/ready interface with a last-beat marker.
module common_dffram_burst_reader #(
  parameter int RAM_DATA_WIDTH = 1,
  parameter int RAM_ADDR_WIDTH = 1,
  parameter int LEN_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic                      abort,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_en,
  output logic                      ram_we,
  input  logic [RAM_DATA_WIDTH-1:0] ram_dout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RAM_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state_reg;
  state_t                    state_next;
  logic [RAM_ADDR_WIDTH-1:0] cur_addr_reg;
  logic [LEN_WIDTH-1:0]      remaining_reg;
  logic                      out_valid_reg;
  logic                      out_last_reg;
  logic [RAM_DATA_WIDTH-1:0] out_data_reg;

  logic slot_free;
  logic issue;
  logic last_xfer;

  // The output register can take a new word when it is empty or being drained
  // this cycle; an abort suppresses the read so nothing is left half-issued.
  assign slot_free = !out_valid_reg || out_ready;
  assign issue     = (state_reg == ST_READ) && slot_free && !abort;
  assign last_xfer = out_valid_reg && out_ready && out_last_reg;

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_data  = out_data_reg;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: accept in IDLE, issue beats in READ, wait for the final
  // handshake in DRAIN; abort returns to IDLE from either busy state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (issue && (remaining_reg == '0)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (last_xfer) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: RAM port is read-only and the address always tracks the
  // current burst pointer, so it is stable whether or not a read is issued.
  always_comb begin
    cmd_ready = (state_reg == ST_IDLE);
    busy      = (state_reg != ST_IDLE);
    ram_en    = issue;
    ram_addr  = cur_addr_reg;
    ram_we    = 1'b0;
  end

  // Burst pointer, beat counter and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else if (state_reg == ST_IDLE) begin
      if (cmd_valid) begin
        cur_addr_reg  <= cmd_addr;
        remaining_reg <= cmd_len;
      end
    end else if (abort) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (issue) begin
      out_data_reg  <= ram_dout;
      out_valid_reg <= 1'b1;
      out_last_reg  <= (remaining_reg == '0);
      if (remaining_reg != '0) begin
        // Address wraps naturally at the top of the RAM.
        cur_addr_reg  <= cur_addr_reg + 1'b1;
        remaining_reg <= remaining_reg - 1'b1;
      end
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_common_dffram_burst_reader.sv
// Bench for common_dffram_burst_reader: an 8-word RAM holding i+0x10, a
// queue-based transaction model checked every cycle, and directed bursts with
// hand-computed beat lists, addresses and timing.
module tb_common_dffram_burst_reader;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       abort;
  logic [2:0] ram_addr;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  logic [7:0] mem [0:7];

  int vectors;
  int errors;
  int cyc;

  // Model state: addresses still to be read, and beats read but not consumed.
  logic [2:0] issue_q [$];
  logic [8:0] beat_q  [$];

  // Logs for directed checks.
  logic [7:0] xfer_data [$];
  logic       xfer_last [$];
  int         xfer_cyc  [$];
  logic [2:0] addr_log  [$];
  int         acc_cyc   [$];
  int         stall_cnt;
  int         last_busy_cyc;

  common_dffram_burst_reader #(
    .RAM_DATA_WIDTH(8),
    .RAM_ADDR_WIDTH(3),
    .LEN_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .abort(abort),
    .ram_addr(ram_addr),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_dout(ram_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
  );

  assign ram_dout = mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    xfer_data.delete();
    xfer_last.delete();
    xfer_cyc.delete();
    addr_log.delete();
    acc_cyc.delete();
    stall_cnt     = 0;
    last_busy_cyc = -1;
  endtask

  // One cycle of the transaction model, evaluated mid-cycle.
  task automatic model_cycle();
    logic       idle_m;
    logic       slot;
    logic       exp_en;
    logic [2:0] a;
    cyc++;
    if (!reset) begin
      issue_q.delete();
      beat_q.delete();
    end else begin
      idle_m = (issue_q.size() == 0) && (beat_q.size() == 0);
      slot   = (beat_q.size() == 0) || out_ready;
      exp_en = (issue_q.size() != 0) && slot && !abort;

      chk("ram_we", 32'(ram_we), 32'(0));
      chk("ram_en", 32'(ram_en), 32'(exp_en));
      if (exp_en) chk("ram_addr", 32'(ram_addr), 32'(issue_q[0]));
      chk("cmd_ready", 32'(cmd_ready), 32'(idle_m));
      chk("busy", 32'(busy), 32'(!idle_m));
      chk("out_valid", 32'(out_valid), 32'(beat_q.size() != 0));
      if (beat_q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(beat_q[0][7:0]));
        chk("out_last", 32'(out_last), 32'(beat_q[0][8]));
      end else begin
        chk("out_last_idle", 32'(out_last), 32'(0));
      end

      // Logs of what the DUT did, for the directed expectations.
      if (out_valid && out_ready) begin
        xfer_data.push_back(out_data);
        xfer_last.push_back(out_last);
        xfer_cyc.push_back(cyc);
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (ram_en) addr_log.push_back(ram_addr);
      if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
      if (busy) last_busy_cyc = cyc;

      // Advance the model.
      if ((beat_q.size() != 0) && out_ready) void'(beat_q.pop_front());
      if (!idle_m && abort) begin
        issue_q.delete();
        beat_q.delete();
      end else if (exp_en) begin
        a = issue_q.pop_front();
        beat_q.push_back({(issue_q.size() == 0), mem[a]});
      end
      if (idle_m && cmd_valid) begin
        for (int i = 0; i <= int'(cmd_len); i++) begin
          issue_q.push_back(cmd_addr + 3'(i));
        end
      end
    end
  endtask

  // Sample mid-cycle, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      if ((issue_q.size() == 0) && (beat_q.size() == 0)) done = 1'b1;
    end
    chk("idle_timeout", 32'(done), 32'(1));
    tick();
  endtask

  // Compare logged transfers against n expected bytes (byte i at [8i+:8]).
  task automatic check_xfers(input string tag, input int n,
                             input logic [31:0] exp_d, input logic [3:0] exp_l);
    chk({tag, "_count"}, 32'(xfer_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < xfer_data.size()) begin
        chk({tag, "_data"}, 32'(xfer_data[i]), 32'(exp_d[8*i +: 8]));
        chk({tag, "_last"}, 32'(xfer_last[i]), 32'(exp_l[i]));
      end
    end
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    cyc       = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 3'd0;
    cmd_len   = 4'd0;
    abort     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    clear_logs();

    // Reset state.
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_ram_en", 32'(ram_en), 32'(0));
    chk("rst_ram_addr", 32'(ram_addr), 32'(0));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    reset = 1'b1;
    tick();

    // Basic burst: addr 2, 4 beats, consumer always ready.
    clear_logs();
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 3'd2; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    run_until_idle(20);
    check_xfers("basic", 4, 32'h15141312, 4'b1000);
    if (acc_cyc.size() == 1 && xfer_cyc.size() == 4) begin
      chk("basic_first_lat", 32'(xfer_cyc[0] - acc_cyc[0]), 32'(2));
      chk("basic_back2back", 32'(xfer_cyc[3] - xfer_cyc[0]), 32'(3));
      chk("basic_busy_drop", 32'(last_busy_cyc), 32'(xfer_cyc[3]));
    end else begin
      chk("basic_log_shape", 32'(acc_cyc.size()), 32'(1));
    end

    // Wrap around the top of the RAM.
    clear_logs();
    cmd_valid = 1'b1; cmd_addr = 3'd6; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    run_until_idle(20);
    check_xfers("wrap", 4, 32'h11101716, 4'b1000);
    chk("wrap_addr_count", 32'(addr_log.size()), 32'(4));
    if (addr_log.size() == 4) begin
      chk("wrap_addr2", 32'(addr_log[2]), 32'(0));
      chk("wrap_addr3", 32'(addr_log[3]), 32'(1));
    end

    // Backpressure: ready pattern 1,0,0,1,1.
    clear_logs();
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 4'd2;
    tick();
    cmd_valid = 1'b0;
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b1; tick();
    run_until_idle(20);
    check_xfers("bp", 3, 32'h00121110, 4'b0100);
    chk("bp_issues", 32'(addr_log.size()), 32'(3));
    chk("bp_stalls", 32'(stall_cnt), 32'(2));

    // Abort on the third valid cycle with ready low, then a fresh command.
    clear_logs();
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 4'd7;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("abort_valid3", 32'(out_valid), 32'(1));
    out_ready = 1'b0; abort = 1'b1;
    tick();
    chk("abort_valid_clr", 32'(out_valid), 32'(0));
    chk("abort_cmd_ready", 32'(cmd_ready), 32'(1));
    // abort held high in IDLE must not block the new command
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 3'd5; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    run_until_idle(20);
    check_xfers("abort", 3, 32'h00151110, 4'b0100);

    // Asynchronous reset while in DRAIN with a beat held.
    clear_logs();
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 3'd3; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'(1));
    chk("drain_busy", 32'(busy), 32'(1));
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_out_last", 32'(out_last), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_ram_en", 32'(ram_en), 32'(0));
    tick();
    tick();
    reset = 1'b1;
    chk("arst_cmd_ready", 32'(cmd_ready), 32'(1));
    tick();

    // Command held valid across a burst: second accept right after last transfer.
    clear_logs();
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 3'd1; cmd_len = 4'd1;
    for (int i = 0; i < 20 && acc_cyc.size() < 2; i++) tick();
    cmd_valid = 1'b0;
    run_until_idle(20);
    chk("hold_accepts", 32'(acc_cyc.size()), 32'(2));
    check_xfers("hold", 4, 32'h12111211, 4'b1010);
    if (acc_cyc.size() == 2 && xfer_cyc.size() == 4) begin
      chk("hold_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(4));
      chk("hold_after_last", 32'(acc_cyc[1]), 32'(xfer_cyc[1] + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
